button_event: RTL and testbench

//  Consumes the debounced, registered level from the debounce stage.

---
 rtl/button_event_pkg.sv | 24 ++
 rtl/hold_timer.sv | 28 ++
 rtl/button_event.sv | 149 ++++++++++++++
 tb/tb_button_event.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// Shared types and elaboration-time helpers for the button_event block.
// Cycle counts derive from clock frequency and millisecond timings.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } btn_state_t;

    // 64-bit product so a 25 MHz clock with multi-second holds cannot overflow.
    function automatic int ms_to_cycles(input longint clk_freq, input longint ms);
        longint cyc;
        cyc = (clk_freq * ms) / 64'sd1000;
        return int'(cyc);
    endfunction

    function automatic int hold_cnt_width(input int long_cyc, input int repeat_cyc);
        int max_cyc;
        max_cyc = (long_cyc > repeat_cyc) ? long_cyc : repeat_cyc;
        return $clog2(max_cyc) + 1;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Clearable up-counter with a terminal-count compare against a run-time threshold.
// Clear has priority over enable; the counter holds when neither is asserted.
module hold_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_value,
    output logic         tc
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign tc = (cnt_reg == tc_value);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into registered press/release/short/long/repeat pulses.
// Auto-repeat while long-held is enabled by defining BUTTON_EVENT_REPEAT_EN.
module button_event
    import button_event_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int LONG_CYC   = ms_to_cycles(longint'(CLK_FREQ), longint'(LONG_MS));
    localparam int REPEAT_CYC = ms_to_cycles(longint'(CLK_FREQ), longint'(REPEAT_MS));
    localparam int CNT_W      = hold_cnt_width(LONG_CYC, REPEAT_CYC);

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);
`endif

    btn_state_t       state_reg, state_next;
    logic             btn_q_reg;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             short_reg, short_next;
    logic             long_reg, long_next;
    logic             repeat_reg, repeat_next;
    logic             held_reg, held_next;
    logic             timer_clr, timer_en, timer_tc;
    logic [CNT_W-1:0] timer_tc_value;
    logic             rise;

    assign rise = btn_level & ~btn_q_reg;

    // One shared timer: the LONG state reuses it for the repeat period.
`ifdef BUTTON_EVENT_REPEAT_EN
    assign timer_tc_value = (state_reg == LONG) ? REPEAT_TC : LONG_TC;
`else
    assign timer_tc_value = LONG_TC;
`endif

    hold_timer #(
        .W(CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .tc_value(timer_tc_value),
        .tc      (timer_tc)
    );

    always_comb begin
        state_next   = state_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        held_next    = (state_reg == LONG);
        timer_clr    = 1'b0;
        timer_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                timer_clr = 1'b1;
                if (rise) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                // Release is tested first so it wins over a coincident threshold.
                if (!btn_level) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    short_next   = 1'b1;
                    timer_clr    = 1'b1;
                end else if (timer_tc) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                    timer_clr  = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            LONG: begin
                if (!btn_level) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    timer_clr    = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (timer_tc) begin
                        repeat_next = 1'b1;
                        timer_clr   = 1'b1;
                    end else begin
                        timer_en = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
                timer_clr  = 1'b1;
            end
        endcase
    end

    // btn_q resets high so a button held through reset is not seen as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            btn_q_reg   <= 1'b1;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            short_reg   <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
            held_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            btn_q_reg   <= btn_level;
            press_reg   <= press_next;
            release_reg <= release_next;
            short_reg   <= short_next;
            long_reg    <= long_next;
            repeat_reg  <= repeat_next;
            held_reg    <= held_next;
        end
    end

    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign short_pulse   = short_reg;
    assign long_pulse    = long_reg;
    assign repeat_pulse  = repeat_reg;
    assign held          = held_reg;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random press patterns against a hold-age model.
// Build with BUTTON_EVENT_REPEAT_EN defined to exercise auto-repeat.
module tb_button_event;

    localparam int CLK_FREQ   = 1000;
    localparam int LONG_MS    = 5;
    localparam int REPEAT_MS  = 2;
    localparam int LONG_CYC   = CLK_FREQ * LONG_MS / 1000;
    localparam int REPEAT_CYC = CLK_FREQ * REPEAT_MS / 1000;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_level = 1'b0;
    logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

    button_event #(
        .CLK_FREQ (CLK_FREQ),
        .LONG_MS  (LONG_MS),
        .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int n = 0;

    // Model: a press is remembered by the sample index it was accepted on;
    // every event is a function of the hold age at the current sample.
    bit m_active = 1'b0;
    bit m_prev = 1'b1;
    bit m_in_long = 1'b0;
    int m_start = 0;
    bit e_press, e_release, e_short, e_long, e_repeat, e_held;

    logic p_press = 1'b0, p_release = 1'b0, p_short = 1'b0, p_long = 1'b0, p_repeat = 1'b0;
    int t_press, t_release, t_short, t_long, t_repeat, t_held;

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        t_press = 0; t_release = 0; t_short = 0; t_long = 0; t_repeat = 0; t_held = 0;
    endtask

    task automatic model_step(input logic lvl, input logic rst);
        int age;
        e_press = 0; e_release = 0; e_short = 0; e_long = 0; e_repeat = 0;
        e_held = m_in_long;
        if (rst) begin
            m_active = 0; m_prev = 1; m_in_long = 0; e_held = 0;
        end else begin
            if (!m_active) begin
                if (lvl && !m_prev) begin
                    e_press = 1; m_active = 1; m_start = n;
                end
            end else begin
                age = n - m_start;
                if (!lvl) begin
                    e_release = 1;
                    e_short = (age <= LONG_CYC);
                    m_active = 0;
                end else begin
                    e_long = (age == LONG_CYC);
                    e_repeat = REP_EN && (age > LONG_CYC) && ((age - LONG_CYC) % REPEAT_CYC == 0);
                end
            end
            m_in_long = m_active && ((n - m_start) >= LONG_CYC);
            m_prev = lvl;
        end
    endtask

    task automatic cycle(input logic lvl, input logic rst);
        btn_level = lvl;
        reset = rst;
        @(posedge clk);
        model_step(lvl, rst);
        #1;
        chk("press", press_pulse, e_press);
        chk("release", release_pulse, e_release);
        chk("short", short_pulse, e_short);
        chk("long", long_pulse, e_long);
        chk("repeat", repeat_pulse, e_repeat);
        chk("held", held, e_held);
        chk("press_excl", press_pulse & (release_pulse | short_pulse | long_pulse | repeat_pulse), 1'b0);
        chk("rel_excl", (release_pulse | short_pulse) & (long_pulse | repeat_pulse), 1'b0);
        chk("consec", (press_pulse & p_press) | (release_pulse & p_release) | (short_pulse & p_short)
                      | (long_pulse & p_long) | (repeat_pulse & p_repeat), 1'b0);
        p_press = press_pulse; p_release = release_pulse; p_short = short_pulse;
        p_long = long_pulse; p_repeat = repeat_pulse;
        t_press += int'(press_pulse); t_release += int'(release_pulse); t_short += int'(short_pulse);
        t_long += int'(long_pulse); t_repeat += int'(repeat_pulse); t_held += int'(held);
        n++;
    endtask

    task automatic run(input logic lvl, input int len);
        for (int i = 0; i < len; i++) cycle(lvl, 1'b0);
    endtask

    initial begin
        clear_tally();

        // 1: short press of 3 cycles
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b1);
        chk("reset_press", press_pulse, 1'b0);
        chk("reset_held", held, 1'b0);
        clear_tally();
        run(1'b0, 2); run(1'b1, 3); run(1'b0, 3);
        chk_int("s1_press", t_press, 1);
        chk_int("s1_short", t_short, 1);
        chk_int("s1_release", t_release, 1);
        chk_int("s1_long", t_long, 0);
        $display("step 1: short press press=%0d short=%0d long=%0d", t_press, t_short, t_long);

        // 2: hold for 12 cycles
        clear_tally();
        run(1'b1, 12); run(1'b0, 3);
        chk_int("s2_long", t_long, 1);
        chk_int("s2_repeat", t_repeat, REP_EN ? 3 : 0);
        chk_int("s2_held", t_held, 7);
        chk_int("s2_short", t_short, 0);
        chk_int("s2_release", t_release, 1);
        $display("step 2: long hold long=%0d repeat=%0d held_cycles=%0d", t_long, t_repeat, t_held);

        // 3: release on the threshold cycle
        clear_tally();
        run(1'b1, LONG_CYC); run(1'b0, 3);
        chk_int("s3_short", t_short, 1);
        chk_int("s3_long", t_long, 0);
        chk_int("s3_release", t_release, 1);
        $display("step 3: boundary release short=%0d long=%0d", t_short, t_long);

        // 4: held through reset
        clear_tally();
        cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);
        run(1'b1, 6);
        chk_int("s4_quiet", t_press + t_release + t_short + t_long + t_repeat, 0);
        run(1'b0, 1); run(1'b1, 2);
        chk_int("s4_press", t_press, 1);
        run(1'b0, 2);
        $display("step 4: held through reset press=%0d", t_press);

        // 5: reset while long-held
        clear_tally();
        run(1'b1, 8);
        chk("s5_held_before", held, 1'b1);
        clear_tally();
        cycle(1'b1, 1'b1);
        chk("s5_held_after", held, 1'b0);
        run(1'b1, 3); run(1'b0, 2);
        chk_int("s5_release", t_release, 0);
        chk_int("s5_press", t_press, 0);
        $display("step 5: reset in long release=%0d press=%0d", t_release, t_press);

        // 6: back-to-back presses
        clear_tally();
        for (int k = 0; k < 10; k++) begin
            run(1'b1, 2); run(1'b0, 2);
        end
        chk_int("s6_press", t_press, 10);
        chk_int("s6_short", t_short, 10);
        chk_int("s6_release", t_release, 10);
        $display("step 6: back-to-back press=%0d short=%0d release=%0d", t_press, t_short, t_release);

        // 7: random level runs with occasional reset
        clear_tally();
        for (int s = 0; s < 60; s++) begin
            logic lvl;
            int len;
            lvl = logic'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) cycle(lvl, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end
        $display("step 7: random press=%0d long=%0d repeat=%0d", t_press, t_long, t_repeat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
